// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Keeps a single request in flight to a variable-latency instruction memory,
// parks a returned word while decode is stalled, and squashes wrong-path
// responses after a branch or jump redirect.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch,
  input  logic        Jump,
  input  logic [31:0] branchAddr,
  input  logic [31:0] jumpAddr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_ID_instr,
  output logic [31:0] IF_ID_PCout,
  output logic [31:0] pc_out
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;

  logic [1:0]  state_r;
  logic [31:0] pc_r;
  logic [31:0] hold_buf_r;
  logic        kill_r;
  logic        req_r;
  logic [31:0] instr_r;
  logic [31:0] pcout_r;

  logic [1:0]  state_n_s;
  logic [31:0] pc_n_s;
  logic [31:0] hold_buf_n_s;
  logic        kill_n_s;
  logic        deliver_s;
  logic [31:0] deliver_data_s;
  logic [31:0] instr_n_s;
  logic [31:0] pcout_n_s;

  logic        redirect_s;
  logic [31:0] target_s;
  logic [31:0] pc_plus4_s;

  // Only jumpAddr[27:0] forms the jump target; the upper nibble comes from PC+4 in ID.
  logic        unused_s;
  assign unused_s = ^jumpAddr[31:28];

  assign pc_plus4_s = pc_r + 32'd4;
  assign redirect_s = (branch | Jump) & ~stall;

  // Redirect target: branch wins over jump; jump keeps the region bits of the ID-stage PC+4.
  always_comb begin
    if (branch) begin
      target_s = branchAddr;
    end else begin
      target_s = {pcout_r[31:28], jumpAddr[27:0]};
    end
  end

  // Fetch sequencer: next state, next PC, response parking and wrong-path squash.
  always_comb begin
    state_n_s      = state_r;
    pc_n_s         = pc_r;
    hold_buf_n_s   = hold_buf_r;
    kill_n_s       = kill_r;
    deliver_s      = 1'b0;
    deliver_data_s = 32'h0000_0000;
    case (state_r)
      IDLE: begin
        state_n_s = REQ;
      end
      REQ: begin
        state_n_s = WAIT;
        if (redirect_s) begin
          // The request just issued belongs to the old path; squash its response.
          pc_n_s   = target_s;
          kill_n_s = 1'b1;
        end else begin
          pc_n_s = pc_r;
        end
      end
      WAIT: begin
        if (imem_rvalid && kill_r) begin
          kill_n_s  = 1'b0;
          state_n_s = REQ;
          if (redirect_s) begin
            pc_n_s = target_s;
          end else begin
            pc_n_s = pc_r;
          end
        end else if (redirect_s) begin
          pc_n_s = target_s;
          if (imem_rvalid) begin
            state_n_s = REQ;
          end else begin
            kill_n_s  = 1'b1;
            state_n_s = WAIT;
          end
        end else if (imem_rvalid && stall) begin
          // Decode cannot accept yet: park the word so it is never lost.
          hold_buf_n_s = imem_rdata;
          state_n_s    = HOLD;
        end else if (imem_rvalid) begin
          deliver_s      = 1'b1;
          deliver_data_s = imem_rdata;
          pc_n_s         = pc_plus4_s;
          state_n_s      = REQ;
        end else begin
          state_n_s = WAIT;
        end
      end
      HOLD: begin
        if (stall) begin
          state_n_s = HOLD;
        end else if (redirect_s) begin
          hold_buf_n_s = 32'h0000_0000;
          pc_n_s       = target_s;
          state_n_s    = REQ;
        end else begin
          deliver_s      = 1'b1;
          deliver_data_s = hold_buf_r;
          pc_n_s         = pc_plus4_s;
          state_n_s      = REQ;
        end
      end
      default: begin
        state_n_s = IDLE;
      end
    endcase
  end

  // IF/ID next value: hold on stall, flush on redirect, load on delivery, otherwise bubble.
  always_comb begin
    instr_n_s = 32'h0000_0000;
    pcout_n_s = 32'h0000_0000;
    if (stall) begin
      instr_n_s = instr_r;
      pcout_n_s = pcout_r;
    end else if (redirect_s) begin
      instr_n_s = 32'h0000_0000;
      pcout_n_s = 32'h0000_0000;
    end else if (deliver_s) begin
      instr_n_s = deliver_data_s;
      pcout_n_s = pc_plus4_s;
    end else begin
      instr_n_s = 32'h0000_0000;
      pcout_n_s = 32'h0000_0000;
    end
  end

  // State, PC, parking buffer and request pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      pc_r       <= RESET_PC;
      hold_buf_r <= 32'h0000_0000;
      kill_r     <= 1'b0;
      req_r      <= 1'b0;
    end else begin
      state_r    <= state_n_s;
      pc_r       <= pc_n_s;
      hold_buf_r <= hold_buf_n_s;
      kill_r     <= kill_n_s;
      req_r      <= (state_n_s == REQ);
    end
  end

  // IF/ID pipeline register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_r <= 32'h0000_0000;
      pcout_r <= 32'h0000_0000;
    end else begin
      instr_r <= instr_n_s;
      pcout_r <= pcout_n_s;
    end
  end

  assign imem_req    = req_r;
  assign imem_addr   = pc_r;
  assign pc_out      = pc_r;
  assign IF_ID_instr = instr_r;
  assign IF_ID_PCout = pcout_r;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: directed stimulus pushes expected fetch
// addresses and IF/ID deliveries; a negedge monitor pops and compares.
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch;
  logic        Jump;
  logic [31:0] branchAddr;
  logic [31:0] jumpAddr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] IF_ID_instr;
  logic [31:0] IF_ID_PCout;
  logic [31:0] pc_out;

  int checks = 0;
  int errors = 0;
  int lat    = 1;

  logic [31:0] exp_addr_q[$];
  logic [63:0] exp_ifid_q[$];

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .branch     (branch),
    .Jump       (Jump),
    .branchAddr (branchAddr),
    .jumpAddr   (jumpAddr),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .IF_ID_instr(IF_ID_instr),
    .IF_ID_PCout(IF_ID_PCout),
    .pc_out     (pc_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_pcout(input logic [31:0] v, input string name);
    bit hit;
    hit = 1'b0;
    for (int n = 0; n < 60 && !hit; n++) begin
      @(posedge clk); #1;
      if (IF_ID_PCout === v) hit = 1'b1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL %s: timeout waiting for IF_ID_PCout %h, last %h", name, v, IF_ID_PCout);
    end
  endtask

  // Memory model: latency 'lat' cycles; word = addr + 0x1000 except addr 8.
  initial begin
    int          cnt;
    logic [31:0] maddr;
    cnt = 0;
    maddr = 32'h0;
    imem_rvalid = 1'b0;
    imem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      imem_rvalid = 1'b0;
      if (!rst) begin
        cnt = 0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = (maddr == 32'h8) ? 32'hAAAA_0001 : maddr + 32'h1000;
          end
        end
        if (imem_req) begin
          maddr = imem_addr;
          cnt   = lat;
        end
      end
    end
  end

  // Monitor: compare every request address and every newly delivered IF/ID entry.
  initial begin
    logic [31:0] prev_instr;
    logic [31:0] prev_pc;
    logic [63:0] e;
    logic [31:0] ea;
    prev_instr = 32'h0;
    prev_pc = 32'h0;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (imem_req) begin
          checks++;
          if (exp_addr_q.size() == 0) begin
            errors++;
            $display("FAIL req_addr: unexpected request to %h", imem_addr);
          end else begin
            ea = exp_addr_q.pop_front();
            if (imem_addr !== ea) begin
              errors++;
              $display("FAIL req_addr: got %h expected %h", imem_addr, ea);
            end
          end
        end
        if (IF_ID_instr != 32'h0 && (IF_ID_instr != prev_instr || IF_ID_PCout != prev_pc)) begin
          checks++;
          if (exp_ifid_q.size() == 0) begin
            errors++;
            $display("FAIL ifid: unexpected delivery %h/%h", IF_ID_instr, IF_ID_PCout);
          end else begin
            e = exp_ifid_q.pop_front();
            if ({IF_ID_instr, IF_ID_PCout} !== e) begin
              errors++;
              $display("FAIL ifid: got %h/%h expected %h/%h", IF_ID_instr, IF_ID_PCout, e[63:32], e[31:0]);
            end
          end
        end
      end
      prev_instr = IF_ID_instr;
      prev_pc    = IF_ID_PCout;
    end
  end

  initial begin
    rst = 1'b0; stall = 1'b0; branch = 1'b0; Jump = 1'b0;
    branchAddr = 32'h0; jumpAddr = 32'h0;

    // Reset values
    @(posedge clk); @(posedge clk); #1;
    check("rst_instr", IF_ID_instr, 32'h0);
    check("rst_pcout", IF_ID_PCout, 32'h0);
    check("rst_req", {31'h0, imem_req}, 32'h0);
    check("rst_pc", pc_out, 32'h0);

    // Test 1: sequential fetch, 1-cycle memory
    exp_addr_q.push_back(32'h0);
    exp_addr_q.push_back(32'h4);
    exp_ifid_q.push_back({32'h0000_1000, 32'h4});
    exp_ifid_q.push_back({32'h0000_1004, 32'h8});
    @(posedge clk); #2; rst = 1'b1;
    check("idle_no_req", {31'h0, imem_req}, 32'h0);
    wait_pcout(32'h4, "t1_first");
    check("t1_instr0", IF_ID_instr, 32'h0000_1000);
    @(posedge clk); #1;
    check("t1_bubble", IF_ID_instr, 32'h0);

    // Test 2: stall spanning the response of pc=8
    exp_addr_q.push_back(32'h8);
    exp_ifid_q.push_back({32'hAAAA_0001, 32'hC});
    wait_pcout(32'h8, "t2_second");
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("t2_frozen_instr", IF_ID_instr, 32'h0000_1004);
      check("t2_no_req", {31'h0, imem_req}, 32'h0);
    end
    check("t2_pc_hold", pc_out, 32'h8);

    // Test 3: branch while waiting on a 3-cycle memory
    exp_addr_q.push_back(32'hC);
    exp_addr_q.push_back(32'h40);
    exp_ifid_q.push_back({32'h0000_1040, 32'h44});
    lat = 3;
    stall = 1'b0;
    wait_pcout(32'hC, "t2_release");
    check("t2_instr", IF_ID_instr, 32'hAAAA_0001);
    @(posedge clk); #1;
    branch = 1'b1; branchAddr = 32'h40;
    @(posedge clk); #1;
    branch = 1'b0;
    check("t3_flush", IF_ID_instr, 32'h0);
    check("t3_pc", pc_out, 32'h40);

    // Test 4: branch in REQ to 0x1000_0004, then jump using IF_ID_PCout region
    wait_pcout(32'h44, "t3_target");
    exp_addr_q.push_back(32'h44);
    exp_addr_q.push_back(32'h1000_0004);
    exp_addr_q.push_back(32'h1000_0008);
    exp_addr_q.push_back(32'h1000_0100);
    exp_ifid_q.push_back({32'h1000_1004, 32'h1000_0008});
    exp_ifid_q.push_back({32'h1000_1100, 32'h1000_0104});
    lat = 1;
    branch = 1'b1; branchAddr = 32'h1000_0004;
    @(posedge clk); #1;
    branch = 1'b0;
    wait_pcout(32'h1000_0008, "t4_setup");
    Jump = 1'b1; jumpAddr = 32'h0000_0100;
    @(posedge clk); #1;
    Jump = 1'b0;
    check("t4_jump_pc", pc_out, 32'h1000_0100);

    // Test 5: branch+jump under stall do nothing; dropping stall takes the branch
    wait_pcout(32'h1000_0104, "t4_target");
    exp_addr_q.push_back(32'h1000_0104);
    exp_addr_q.push_back(32'h200);
    exp_ifid_q.push_back({32'h0000_1200, 32'h204});
    stall = 1'b1; branch = 1'b1; Jump = 1'b1;
    branchAddr = 32'h200; jumpAddr = 32'h300;
    @(posedge clk); #1;
    check("t5_pc_hold1", pc_out, 32'h1000_0104);
    @(posedge clk); #1;
    check("t5_pc_hold2", pc_out, 32'h1000_0104);
    check("t5_ifid_hold", IF_ID_instr, 32'h1000_1100);
    stall = 1'b0;
    @(posedge clk); #1;
    branch = 1'b0; Jump = 1'b0;
    check("t5_pc", pc_out, 32'h200);
    check("t5_flush", IF_ID_instr, 32'h0);

    // Test 6: asynchronous reset in the middle of a WAIT
    wait_pcout(32'h204, "t5_target");
    exp_addr_q.push_back(32'h204);
    lat = 3;
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("t6_instr", IF_ID_instr, 32'h0);
    check("t6_pcout", IF_ID_PCout, 32'h0);
    check("t6_req", {31'h0, imem_req}, 32'h0);
    check("t6_pc", pc_out, 32'h0);
    check("t6_addr", imem_addr, 32'h0);
    exp_addr_q.push_back(32'h0);
    exp_addr_q.push_back(32'h4);
    exp_ifid_q.push_back({32'h0000_1000, 32'h4});
    lat = 1;
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b1;
    wait_pcout(32'h4, "t6_refetch");
    stall = 1'b1;
    for (int i = 0; i < 6; i++) @(posedge clk);
    #1;
    check("addr_q_empty", exp_addr_q.size(), 32'h0);
    check("ifid_q_empty", exp_ifid_q.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
